// File: rtl/scan_decoder_pkg.sv
// rtl/scan_decoder_pkg.sv - shared helpers for the scan decoder
package scan_decoder_pkg;

    // Prescaler width: at least one bit, even when DIV is 1 or 2.
    function automatic int cnt_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

    // Level of an inactive select line for the given polarity setting.
    function automatic logic idle_bit(input int active_low);
        return (active_low != 0) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/scan_decoder_tick_gen.sv
// rtl/scan_decoder_tick_gen.sv - scan-step prescaler
module tick_gen
    import scan_decoder_pkg::*;
#(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic tick
);

    localparam int CW = cnt_width(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Step strobe for the current cycle; the parent registers it so the
    // index update and the visible tick land on the same edge.
    assign tick = run && (cnt == LAST);

    // Count 0..DIV-1 while running, park at 0 otherwise.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (!run) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// rtl/scan_decoder.sv - manual/auto-scan one-hot select decoder
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int N          = 3,
    parameter int DIV        = 100000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             mode,
    input  logic [N-1:0]     w,
    input  logic [0:2**N-1]  mask,
    output logic [0:2**N-1]  y,
    output logic [N-1:0]     idx,
    output logic             tick
);

    localparam int M = 2**N;
    localparam logic [0:M-1] Y_IDLE = {M{idle_bit(ACTIVE_LOW)}};

    logic            run;
    logic            step;
    logic [N-1:0]    next_idx;
    logic [0:M-1]    next_y;

    assign run = en && mode;

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (run),
        .tick    (step)
    );

    // Next index and its decoded select, so y and idx move together.
    always_comb begin
        next_idx = idx;
        next_y   = Y_IDLE;
        if (en) begin
            if (mode) begin
                if (step) begin
                    next_idx = idx + N'(1);
                end
            end else begin
                next_idx = w;
            end
            if (mask[next_idx]) begin
                next_y[next_idx] = ~idle_bit(ACTIVE_LOW);
            end
        end
    end

    // Output registers; reset aborts any step in progress.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx  <= '0;
            tick <= 1'b0;
            y    <= Y_IDLE;
        end else begin
            idx  <= next_idx;
            tick <= step;
            y    <= next_y;
        end
    end

endmodule
